// File: rtl/replay_pkg.sv
// Shared definitions for the anti_replay front-end sequencer: register map,
// STATUS bit positions, CTRL reset value and the sequencer FSM encoding.
package replay_pkg;

  localparam logic [4:0] REG_ID            = 5'h00;
  localparam logic [4:0] REG_CHECK_COUNTER = 5'h04;
  localparam logic [4:0] REG_CHECK_NONCE   = 5'h08;
  localparam logic [4:0] REG_VALIDATE      = 5'h0C;
  localparam logic [4:0] REG_STATUS        = 5'h10;
  localparam logic [4:0] REG_LAST_COUNTER  = 5'h14;
  localparam logic [4:0] REG_CTRL          = 5'h18;

  localparam int ST_VALID       = 0;
  localparam int ST_REPLAY      = 1;
  localparam int ST_BAD_COUNTER = 2;
  localparam int ST_BAD_NONCE   = 3;

  // CTRL bit0 clears the nonce cache, bit1 clears the last-counter state.
  localparam logic [31:0] CTRL_RESET_VAL = 32'h0000_0003;
  localparam logic [31:0] VALIDATE_GO    = 32'h0000_0001;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_IDLE      = 4'd1,
    S_CAP_NONCE = 4'd2,
    S_WR_CNT    = 4'd3,
    S_WR_NONCE  = 4'd4,
    S_WR_VAL    = 4'd5,
    S_WAIT      = 4'd6,
    S_RD_ADDR   = 4'd7,
    S_RD_LATCH  = 4'd8,
    S_VERDICT   = 4'd9
  } seq_state_e;

  function automatic logic reg_is_read_only(input logic [4:0] addr);
    return (addr == REG_ID) || (addr == REG_STATUS) || (addr == REG_LAST_COUNTER);
  endfunction

  function automatic logic status_is_reject(input logic [3:0] status);
    return status[ST_REPLAY] | status[ST_BAD_COUNTER] | status[ST_BAD_NONCE] | ~status[ST_VALID];
  endfunction

endpackage

// File: rtl/replay_check_sequencer.sv
// Turns {counter, nonce} header pairs into anti_replay register sequences and
// returns a registered verdict. REPLAY_SEQ_STATS_EN adds accept/reject counters.
module replay_check_sequencer
  import replay_pkg::*;
#(
  parameter int STATUS_WAIT   = 2,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        v_valid,
  input  logic        v_ready,
  output logic        v_accept,
  output logic [3:0]  v_status,
  output logic        v_frame_err,
  output logic [31:0] v_counter,
  output logic [4:0]  ar_addr,
  output logic        ar_we,
  output logic [31:0] ar_wdata,
  input  logic [31:0] ar_rdata,
  output logic        busy,
`ifdef REPLAY_SEQ_STATS_EN
  output logic [15:0] stat_accept,
  output logic [15:0] stat_reject,
`endif
  output seq_state_e  dbg_state
);

  // Handshakes: a word/verdict transfers on a rising edge where valid and ready
  // are both high; a producer holds valid and its payload stable until then.

  localparam logic [4:0] WAIT_LOAD = 5'(STATUS_WAIT - 1);

  seq_state_e  state;
  logic [31:0] cnt_q;
  logic [31:0] nonce_q;
  logic [4:0]  wait_cnt;
  logic        init_sent;
  logic        unused_rdata;

  assign unused_rdata = ^ar_rdata[31:4];
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= INIT_ON_RESET ? S_INIT : S_IDLE;
      cnt_q       <= '0;
      nonce_q     <= '0;
      wait_cnt    <= '0;
      init_sent   <= 1'b0;
      s_ready     <= 1'b0;
      v_valid     <= 1'b0;
      v_accept    <= 1'b0;
      v_status    <= '0;
      v_frame_err <= 1'b0;
      v_counter   <= '0;
      ar_addr     <= '0;
      ar_we       <= 1'b0;
      ar_wdata    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        // Outputs are registered, so INIT spends one cycle arming the CTRL
        // write and one cycle presenting it on the port.
        S_INIT: begin
          busy <= 1'b1;
          if (!init_sent) begin
            init_sent <= 1'b1;
            ar_we     <= 1'b1;
            ar_addr   <= REG_CTRL;
            ar_wdata  <= CTRL_RESET_VAL;
          end else begin
            ar_we    <= 1'b0;
            ar_addr  <= '0;
            ar_wdata <= '0;
            busy     <= 1'b0;
            s_ready  <= 1'b1;
            state    <= S_IDLE;
          end
        end

        S_IDLE: begin
          ar_we    <= 1'b0;
          ar_addr  <= '0;
          ar_wdata <= '0;
          busy     <= 1'b0;
          s_ready  <= 1'b1;
          if (s_valid && s_ready) begin
            cnt_q <= s_data;
            busy  <= 1'b1;
            if (s_last) begin
              s_ready     <= 1'b0;
              v_valid     <= 1'b1;
              v_frame_err <= 1'b1;
              v_accept    <= 1'b0;
              v_status    <= '0;
              v_counter   <= s_data;
              state       <= S_VERDICT;
            end else begin
              state <= S_CAP_NONCE;
            end
          end
        end

        S_CAP_NONCE: begin
          if (s_valid && s_ready) begin
            nonce_q <= s_data;
            s_ready <= 1'b0;
            if (!s_last) begin
              v_valid     <= 1'b1;
              v_frame_err <= 1'b1;
              v_accept    <= 1'b0;
              v_status    <= '0;
              v_counter   <= cnt_q;
              state       <= S_VERDICT;
            end else begin
              ar_we    <= 1'b1;
              ar_addr  <= REG_CHECK_COUNTER;
              ar_wdata <= cnt_q;
              state    <= S_WR_CNT;
            end
          end
        end

        S_WR_CNT: begin
          ar_addr  <= REG_CHECK_NONCE;
          ar_wdata <= nonce_q;
          state    <= S_WR_NONCE;
        end

        S_WR_NONCE: begin
          ar_addr  <= REG_VALIDATE;
          ar_wdata <= VALIDATE_GO;
          state    <= S_WR_VAL;
        end

        S_WR_VAL: begin
          ar_we    <= 1'b0;
          ar_addr  <= '0;
          ar_wdata <= '0;
          wait_cnt <= WAIT_LOAD;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == 5'd0) begin
            ar_addr <= REG_STATUS;
            state   <= S_RD_ADDR;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end

        // The checker returns read data one cycle after the address.
        S_RD_ADDR: begin
          ar_addr <= '0;
          state   <= S_RD_LATCH;
        end

        S_RD_LATCH: begin
          v_status    <= ar_rdata[3:0];
          v_accept    <= ar_rdata[ST_VALID];
          v_frame_err <= 1'b0;
          v_counter   <= cnt_q;
          v_valid     <= 1'b1;
          state       <= S_VERDICT;
        end

        S_VERDICT: begin
          if (v_ready) begin
            v_valid <= 1'b0;
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= S_IDLE;
          end
        end

        default: begin
          ar_we   <= 1'b0;
          v_valid <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REPLAY_SEQ_STATS_EN
  // Frame errors carry v_accept=0 and therefore land in the reject count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_accept <= '0;
      stat_reject <= '0;
    end else if (v_valid && v_ready) begin
      if (v_accept) begin
        if (stat_accept != 16'hFFFF) stat_accept <= stat_accept + 16'd1;
      end else begin
        if (stat_reject != 16'hFFFF) stat_reject <= stat_reject + 16'd1;
      end
    end
  end
`endif

endmodule
